// File: rtl/latch_wr_sched.sv
// latch_wr_sched: round-robin write scheduler for a shared D-latch bank.
// Drives lat_d/lat_en through SETUP -> ENABLE -> HOLD, then pulses ack.
// Ports: clk, rst (async, active-high), req[NREQ], wdata[NREQ*DW],
//   ack[NREQ] (one-hot pulse), lat_d[DW], lat_en, busy, owner.
// Option: LATCH_WR_FIXED_PRIO_EN selects fixed lowest-index priority.
module latch_wr_sched #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       wdata,
  output logic [NREQ-1:0]          ack,
  output logic [DW-1:0]            lat_d,
  output logic                     lat_en,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_EN    = 3'd2,
    S_HOLD  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   lat_d_q, lat_d_d;
  logic            lat_en_q, lat_en_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   start;

  logic            found;
  logic [OW-1:0]   win;
  logic [DW-1:0]   win_data;
  int              idx;

`ifdef LATCH_WR_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [OW-1:0] ptr_q, ptr_d;

  // Pointer moves past the requester just served.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_ACK) begin
      if (int'(owner_q) == NREQ-1) ptr_d = '0;
      else                         ptr_d = owner_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign start = ptr_q;
`endif

  // First active request searching from start, wrapping.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win      = OW'(idx);
        win_data = wdata[idx*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d_d = lat_d_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          lat_d_d = win_data;
          owner_d = win;
        end
      end
      S_SETUP: begin
        if (cnt_q == CW'(SETUP_CYC-1)) begin
          state_d = S_EN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EN: begin
        if (cnt_q == CW'(EN_CYC-1)) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(HOLD_CYC-1)) begin
          state_d = S_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are registered from next state so they switch only on edges.
  always_comb begin
    lat_en_d = (state_d == S_EN);
    ack_d    = '0;
    if (state_d == S_ACK) ack_d[owner_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lat_d_q  <= '0;
      lat_en_q <= 1'b0;
      ack_q    <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
      ack_q    <= ack_d;
      owner_q  <= owner_d;
    end
  end

  assign ack    = ack_q;
  assign lat_d  = lat_d_q;
  assign lat_en = lat_en_q;
  assign owner  = owner_q;
  assign busy   = (state_q != S_IDLE);

endmodule
